// File: rtl/prot_latch_ctrl_if.sv
// Protection latch interface: DSP-side commands and fault inputs toward the
// latch controller, gated drive and status flags back out.
interface prot_latch_ctrl_if;
    // Debounced fault inputs, active-low (0 = fault)
    logic       IP_Ocp_F;
    logic       InvOcp1_F;
    logic       InvOcp2_F;
    logic       BusOvp_F;
    logic       OP_Ovp1_F;
    logic       OP_Ovp2_F;
    // DSP commands
    logic [7:0] PWM_In;
    logic       Fault_Clr;
    // Controller outputs
    logic [7:0] PWM_Out;
    logic       Fault_N;
    logic       Ready;
    logic [5:0] Fault_Code;
    logic [2:0] First_Fault;

    // Stimulus side: drives faults and DSP commands, observes the controller
    modport master (
        output IP_Ocp_F, InvOcp1_F, InvOcp2_F, BusOvp_F, OP_Ovp1_F, OP_Ovp2_F,
        output PWM_In, Fault_Clr,
        input  PWM_Out, Fault_N, Ready, Fault_Code, First_Fault
    );

    // Controller side
    modport slave (
        input  IP_Ocp_F, InvOcp1_F, InvOcp2_F, BusOvp_F, OP_Ovp1_F, OP_Ovp2_F,
        input  PWM_In, Fault_Clr,
        output PWM_Out, Fault_N, Ready, Fault_Code, First_Fault
    );
endinterface

// File: rtl/prot_latch_ctrl.sv
// Protection latch controller: blanks gate drive on any fault, latches which
// faults occurred (and which came first), and enforces a fixed lockout
// period after reset and after every DSP-initiated fault clear.
module prot_latch_ctrl #(
    parameter int LOCK_CYC = 50000
) (
    input  logic              CLK_50M,
    input  logic              Rst_n,
    prot_latch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        LOCKOUT = 2'd0,
        RUN     = 2'd1,
        FAULT   = 2'd2
    } state_t;

    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYC - 1);

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [7:0]  pwm_reg, pwm_next;
    logic        fault_n_reg, fault_n_next;
    logic [5:0]  code_reg, code_next;
    logic [2:0]  first_reg, first_next;

    logic [5:0]  flt_vec;
    logic        any_flt;
    logic [2:0]  first_idx;

    // Fault vector in Fault_Code bit order, active-high
    assign flt_vec = ~{bus.OP_Ovp2_F, bus.OP_Ovp1_F, bus.BusOvp_F,
                       bus.InvOcp2_F, bus.InvOcp1_F, bus.IP_Ocp_F};
    assign any_flt = |flt_vec;

    // Priority encode: lowest set bit wins, reported 1-based (0 = none)
    always_comb begin
        first_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (flt_vec[i]) first_idx = 3'(i + 1);
        end
    end

    // Register all state and outputs; reset overrides everything else
    always_ff @(posedge CLK_50M) begin
        if (!Rst_n) begin
            state_reg   <= LOCKOUT;
            cnt_reg     <= 16'd0;
            pwm_reg     <= 8'h00;
            fault_n_reg <= 1'b1;
            code_reg    <= 6'b0;
            first_reg   <= 3'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pwm_reg     <= pwm_next;
            fault_n_reg <= fault_n_next;
            code_reg    <= code_next;
            first_reg   <= first_next;
        end
    end

    // Next-state and output decision; drive is blank unless running fault-free
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pwm_next     = 8'h00;
        fault_n_next = fault_n_reg;
        code_next    = code_reg;
        first_next   = first_reg;

        unique case (state_reg)
            LOCKOUT: begin
                if (any_flt) begin
                    // Code and first-fault are clear in lockout, so load directly
                    state_next   = FAULT;
                    cnt_next     = 16'd0;
                    fault_n_next = 1'b0;
                    code_next    = flt_vec;
                    first_next   = first_idx;
                end else if (cnt_reg == LOCK_LAST) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            RUN: begin
                if (any_flt) begin
                    state_next   = FAULT;
                    fault_n_next = 1'b0;
                    code_next    = code_reg | flt_vec;
                    first_next   = first_idx;
                end else begin
                    pwm_next = bus.PWM_In;
                end
            end
            FAULT: begin
                // Later faults accumulate; the first-fault index stays put
                code_next = code_reg | flt_vec;
                // A clear is honoured only once every fault input is healthy
                if (bus.Fault_Clr && !any_flt) begin
                    state_next   = LOCKOUT;
                    cnt_next     = 16'd0;
                    fault_n_next = 1'b1;
                    code_next    = 6'b0;
                    first_next   = 3'd0;
                end
            end
            default: begin
                state_next = LOCKOUT;
                cnt_next   = 16'd0;
            end
        endcase
    end

    assign bus.PWM_Out     = pwm_reg;
    assign bus.Fault_N     = fault_n_reg;
    assign bus.Ready       = (state_reg == RUN);
    assign bus.Fault_Code  = code_reg;
    assign bus.First_Fault = first_reg;

endmodule

// File: tb/tb_prot_latch_ctrl.sv
// Directed bench for prot_latch_ctrl with a shortened lockout period.
module tb_prot_latch_ctrl;

    localparam int L = 20;

    typedef struct {
        string      tag;
        logic [7:0] pwm;
        logic       fault_n;
        logic       ready;
        logic [5:0] code;
        logic [2:0] first;
    } exp_t;

    logic CLK_50M = 1'b0;
    logic Rst_n   = 1'b0;

    exp_t exp_q[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    prot_latch_ctrl_if ifc ();

    prot_latch_ctrl #(.LOCK_CYC(L)) dut (
        .CLK_50M (CLK_50M),
        .Rst_n   (Rst_n),
        .bus     (ifc.slave)
    );

    always #10 CLK_50M = ~CLK_50M;

    // Compare one observed field against its expectation
    task automatic chk(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, clock, then check
    // flt: active-high fault bits in Fault_Code order
    task automatic step(input string tag, input logic rst_n_v, input logic [7:0] pwm_in,
                        input logic [5:0] flt, input logic clr,
                        input logic [7:0] e_pwm, input logic e_fn, input logic e_rdy,
                        input logic [5:0] e_code, input logic [2:0] e_first);
        exp_t e;
        exp_t got;
        Rst_n         = rst_n_v;
        ifc.PWM_In    = pwm_in;
        ifc.Fault_Clr = clr;
        ifc.IP_Ocp_F  = ~flt[0];
        ifc.InvOcp1_F = ~flt[1];
        ifc.InvOcp2_F = ~flt[2];
        ifc.BusOvp_F  = ~flt[3];
        ifc.OP_Ovp1_F = ~flt[4];
        ifc.OP_Ovp2_F = ~flt[5];
        e.tag = tag; e.pwm = e_pwm; e.fault_n = e_fn; e.ready = e_rdy;
        e.code = e_code; e.first = e_first;
        exp_q.push_back(e);
        @(posedge CLK_50M);
        #1;
        got = exp_q.pop_front();
        chk(got.tag, "PWM_Out",     ifc.PWM_Out,           got.pwm);
        chk(got.tag, "Fault_N",     8'(ifc.Fault_N),       8'(got.fault_n));
        chk(got.tag, "Ready",       8'(ifc.Ready),         8'(got.ready));
        chk(got.tag, "Fault_Code",  8'(ifc.Fault_Code),    8'(got.code));
        chk(got.tag, "First_Fault", 8'(ifc.First_Fault),   8'(got.first));
        $display("step %-12s pwm=%h fn=%b rdy=%b code=%b first=%0d", tag,
                 ifc.PWM_Out, ifc.Fault_N, ifc.Ready, ifc.Fault_Code, ifc.First_Fault);
    endtask

    // Full fault-free lockout: Ready must appear on exactly the L-th edge.
    // Fault_Clr toggles throughout to show it has no effect here.
    task automatic lockout_run(input string tag, input logic [7:0] pwm_in);
        for (int i = 1; i <= L; i++) begin
            step(tag, 1'b1, pwm_in, 6'b0, 1'(i % 2), 8'h00, 1'b1, (i == L), 6'b0, 3'd0);
        end
    endtask

    initial begin
        // Reset with drive commanded
        step("reset0", 1'b0, 8'hA5, 6'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'b0, 3'd0);
        step("reset1", 1'b0, 8'hA5, 6'b0, 1'b1, 8'h00, 1'b1, 1'b0, 6'b0, 3'd0);

        // Start-up blanking, then drive passes one edge after Ready
        lockout_run("startup", 8'hA5);
        step("run_a5",   1'b1, 8'hA5, 6'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 6'b0, 3'd0);
        step("run_3c",   1'b1, 8'h3C, 6'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 6'b0, 3'd0);

        // Single-cycle InvOcp1 fault latches and holds
        step("invocp1",  1'b1, 8'h3C, 6'b000010, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000010, 3'd2);
        step("hold1",    1'b1, 8'h3C, 6'b0,      1'b0, 8'h00, 1'b0, 1'b0, 6'b000010, 3'd2);
        step("hold2",    1'b1, 8'h3C, 6'b0,      1'b0, 8'h00, 1'b0, 1'b0, 6'b000010, 3'd2);

        // Later fault ORs in, first fault holds; clear ignored while faulted
        step("ovp2_clr", 1'b1, 8'h3C, 6'b100000, 1'b1, 8'h00, 1'b0, 1'b0, 6'b100010, 3'd2);
        step("ovp2_hold",1'b1, 8'h3C, 6'b100000, 1'b0, 8'h00, 1'b0, 1'b0, 6'b100010, 3'd2);
        step("noclr",    1'b1, 8'h3C, 6'b0,      1'b0, 8'h00, 1'b0, 1'b0, 6'b100010, 3'd2);
        step("clear1",   1'b1, 8'h3C, 6'b0,      1'b1, 8'h00, 1'b1, 1'b0, 6'b0,      3'd0);

        // Fault mid-lockout, then a full lockout after the next clear
        for (int i = 1; i <= 12; i++) begin
            step("lock_mid", 1'b1, 8'h3C, 6'b0, 1'(i % 2), 8'h00, 1'b1, 1'b0, 6'b0, 3'd0);
        end
        step("ovp1_lock",1'b1, 8'h3C, 6'b010000, 1'b0, 8'h00, 1'b0, 1'b0, 6'b010000, 3'd5);
        step("clear2",   1'b1, 8'h3C, 6'b0,      1'b1, 8'h00, 1'b1, 1'b0, 6'b0,      3'd0);
        lockout_run("relock", 8'h3C);
        step("run_5a",   1'b1, 8'h5A, 6'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 6'b0, 3'd0);

        // Simultaneous BusOvp + IP_Ocp: both bits, IP_Ocp reported first
        step("dual",     1'b1, 8'h5A, 6'b001001, 1'b0, 8'h00, 1'b0, 1'b0, 6'b001001, 3'd1);
        step("dual_hold",1'b1, 8'hFF, 6'b0,      1'b0, 8'h00, 1'b0, 1'b0, 6'b001001, 3'd1);

        // Reset in FAULT overrides a fault and a clear on the same edge
        step("rst_fault",1'b0, 8'hFF, 6'b000100, 1'b1, 8'h00, 1'b1, 1'b0, 6'b0, 3'd0);
        lockout_run("post_rst", 8'hFF);
        step("run_ff",   1'b1, 8'hFF, 6'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 6'b0, 3'd0);
        step("run_clr",  1'b1, 8'h81, 6'b0, 1'b1, 8'h81, 1'b1, 1'b1, 6'b0, 3'd0);

        // Reset mid-lockout restarts the full count
        step("ocp2",     1'b1, 8'h81, 6'b000100, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000100, 3'd3);
        step("clear3",   1'b1, 8'h81, 6'b0,      1'b1, 8'h00, 1'b1, 1'b0, 6'b0,      3'd0);
        for (int i = 1; i <= 10; i++) begin
            step("lock_pre", 1'b1, 8'h81, 6'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'b0, 3'd0);
        end
        step("rst_lock", 1'b0, 8'h81, 6'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'b0, 3'd0);
        lockout_run("post_rst2", 8'h81);
        step("run_81",   1'b1, 8'h81, 6'b0, 1'b0, 8'h81, 1'b1, 1'b1, 6'b0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/prot_latch_ctrl.md
PROT_LATCH_CTRL -- requirements
Module: prot_latch_ctrl

Interface
REQ-001 SHALL have the following parameter: LOCK_CYC, default 50000, lockout length in CLK_50M cycles (1 ms); legal range 2..65535.
REQ-002 SHALL have port CLK_50M  in  1  system clock, 50 MHz; all logic on its rising edge.
REQ-003 SHALL have port Rst_n  in  1  reset; synchronous, active-low; clock CLK_50M.
REQ-004 SHALL have ports IP_Ocp_F, InvOcp1_F, InvOcp2_F, BusOvp_F, OP_Ovp1_F, OP_Ovp2_F  in  1 each  debounced fault inputs; active-low (0 = fault).
REQ-005 SHALL have port PWM_In  in  8  gate commands from the DSP.
REQ-006 SHALL have port Fault_Clr  in  1  DSP clear request; active-high level, sampled each cycle.
REQ-007 SHALL have port PWM_Out  out  8  gated drive to the gate drivers; registered.
REQ-008 SHALL have port Fault_N  out  1  trip flag to the DSP; active-low, 0 only in FAULT; registered.
REQ-009 SHALL have port Ready  out  1  1 only in RUN; decoded from the state register.
REQ-010 SHALL have port Fault_Code  out  6  sticky fault bits; bit0..5 = IP_Ocp, InvOcp1, InvOcp2, BusOvp, OP_Ovp1, OP_Ovp2.
REQ-011 SHALL have port First_Fault  out  3  index of the first fault; 1..6 in bit order above; 0 = none.

Function
REQ-012 SHALL implement a 3-state FSM: LOCKOUT, RUN, FAULT.
REQ-013 any_flt SHALL be the OR of the six inverted fault inputs, sampled at the current edge.
REQ-014 PWM_Out SHALL load PWM_In when state==RUN and any_flt==0, else 8'h00; fault-to-blank latency is 1 edge, no intermediate value.
REQ-015 RUN -> FAULT on the edge any_flt==1; same edge: matching Fault_Code bits set, First_Fault captured, Fault_N<=0.
REQ-016 Simultaneous faults SHALL set all matching Fault_Code bits; First_Fault takes the lowest set bit index (IP_Ocp highest priority).
REQ-017 In FAULT, further faults SHALL OR into Fault_Code; First_Fault SHALL hold.
REQ-018 FAULT -> LOCKOUT only on an edge where Fault_Clr==1 and any_flt==0; Fault_Clr with any_flt==1 SHALL be ignored, no memory of the request.
REQ-019 On FAULT -> LOCKOUT: Fault_Code<=0, First_Fault<=0, Fault_N<=1, lockout counter<=0.
REQ-020 In LOCKOUT, the 16-bit counter increments by 1 per cycle; on the edge it equals LOCK_CYC-1, state -> RUN; LOCKOUT lasts exactly LOCK_CYC cycles; no wrap.
REQ-021 any_flt==1 in LOCKOUT SHALL go to FAULT, latch per REQ-015/016, and zero the counter.
REQ-022 Fault_Clr in RUN or LOCKOUT SHALL have no effect.
REQ-023 PWM_Out SHALL be 8'h00 throughout LOCKOUT and FAULT.

Reset
REQ-024 On Rst_n==0 at an edge: state<=LOCKOUT, counter<=0, PWM_Out<=8'h00, Fault_N<=1, Fault_Code<=6'b0, First_Fault<=3'd0; Ready==0.
REQ-025 Reset SHALL override every other event on the same edge, including mid-FAULT and mid-LOCKOUT.
REQ-026 After reset release, the block SHALL pass through a full LOCK_CYC lockout before RUN (start-up blanking).

Verification
REQ-027 Release reset, PWM_In=8'hA5, no faults -> Ready rises after exactly 50000 cycles; PWM_Out=8'hA5 one edge later.
REQ-028 In RUN, InvOcp1_F=0 for one cycle -> at that edge PWM_Out=00, Fault_N=0, Fault_Code=6'b000010, First_Fault=2; all hold after input returns high.
REQ-029 In RUN, BusOvp_F and IP_Ocp_F low on the same edge -> Fault_Code=6'b001001, First_Fault=1.
REQ-030 In FAULT, Fault_Clr=1 while OP_Ovp2_F=0 -> stays FAULT; release OP_Ovp2_F, Fault_Clr=1 -> LOCKOUT, Fault_Code=0, Fault_N=1.
REQ-031 OP_Ovp1_F=0 at lockout cycle 30000 -> FAULT, Fault_Code=6'b010000, First_Fault=5; after a new clear, a full 50000-cycle lockout runs.
REQ-032 Assert Rst_n=0 in FAULT with PWM_In=8'hFF -> all outputs at reset values next edge; lockout restarts from 0.
